// File: rtl/load_store_unit.sv
// load_store_unit: word-wide data-memory initiator for byte/half/word loads and stores with read-modify-write.
// Define MISALIGN_TRAP_EN to report misaligned half/word requests as errors instead of masking the low address bits.
module load_store_unit #(
    parameter int MEM_BYTES = 65536,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES - 4);
    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_err;
    logic [4:0]        sh;
    logic [15:0]       lane;
    logic [31:0]       mask, ext, merged;
`ifdef MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign req_err  = req_size == 2'b11 || misalign || {req_addr[ADDR_W-1:2], 2'b00} >= LIMIT;
`else
    assign req_err  = req_size == 2'b11 || {req_addr[ADDR_W-1:2], 2'b00} >= LIMIT;
`endif
    // Half lanes ignore addr[0], so an untrapped misaligned half lands on its enclosing half.
    assign sh     = size_q == 2'b01 ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    assign lane   = 16'(mem_rdata >> sh);
    assign mask   = size_q == 2'b00 ? 32'hFF << sh : 32'hFFFF << sh;
    assign ext    = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                    size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : mem_rdata;
    assign merged = (mem_rdata & ~mask) | ((word_q << sh) & mask);
    assign req_ready = state_q == IDLE;
    assign mem_read  = state_q == LOAD || state_q == RMW_RD;
    assign mem_write = state_q == STORE;
    assign mem_addr  = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_write ? word_q : '0;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                size_d  = req_size;
                uns_d   = req_unsigned;
                addr_d  = req_addr;
                word_d  = req_wdata;
                rdata_d = '0;
                err_d   = req_err;
                state_d = req_err ? RESP : !req_we ? LOAD : req_size == 2'b10 ? STORE : RMW_RD;
            end
            LOAD: begin
                rdata_d = ext;
                state_d = RESP;
            end
            RMW_RD: begin
                word_d  = merged;
                state_d = STORE;
            end
            STORE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized load/store traffic checked against a byte-array reference memory.
module tb_load_store_unit;
    localparam int MEM_BYTES = 65536;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic rsp_valid, rsp_err, mem_read, mem_write;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] dmem [MEM_BYTES/4];
    logic [7:0] ref_mem [MEM_BYTES];
    int n_chk = 0, n_fail = 0;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    always #5 clk = ~clk;
    assign mem_rdata = dmem[mem_addr[15:2]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[15:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [15:0] b = {a[15:2], 2'b00};
        return {ref_mem[b + 16'd3], ref_mem[b + 16'd2], ref_mem[b + 16'd1], ref_mem[b]};
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd);
        logic e_err, got;
        logic [31:0] e_rd, e_wword, al;
        int e_lat, e_nrd, e_nwr, nrd, nwr;
        logic [15:0] hb;
        al = a & ~32'd3;
        hb = a[15:0] & ~16'd1;
        e_err = sz == 2'd3 || al >= MEM_BYTES - 4 ||
                (TRAP && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)));
        e_rd = 0; e_wword = 0;
        if (e_err) begin
            e_lat = 1; e_nrd = 0; e_nwr = 0;
        end else if (!we) begin
            e_lat = 2; e_nrd = 1; e_nwr = 0;
            if (sz == 2'd0) e_rd = un ? 32'(ref_mem[a[15:0]]) : 32'(signed'(ref_mem[a[15:0]]));
            else if (sz == 2'd1) e_rd = un ? 32'({ref_mem[hb + 16'd1], ref_mem[hb]})
                                           : 32'(signed'({ref_mem[hb + 16'd1], ref_mem[hb]}));
            else e_rd = ref_word(a);
        end else begin
            e_nwr = 1;
            e_nrd = sz == 2'd2 ? 0 : 1;
            e_lat = sz == 2'd2 ? 2 : 3;
            if (sz == 2'd0) ref_mem[a[15:0]] = wd[7:0];
            else if (sz == 2'd1) {ref_mem[hb + 16'd1], ref_mem[hb]} = wd[15:0];
            else for (int i = 0; i < 4; i++) ref_mem[al[15:0] + 16'(i)] = wd[8*i +: 8];
            e_wword = ref_word(a);
        end
        @(negedge clk);
        check("ready", req_ready, 1);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        @(posedge clk);
        nrd = 0; nwr = 0; got = 0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            check("rw_excl", mem_read & mem_write, 0);
            check("busy_ready", req_ready, 0);
            if (mem_read || mem_write) begin
                check("mem_addr", mem_addr, al);
                nrd += int'(mem_read);
                nwr += int'(mem_write);
                if (mem_write) check("mem_wdata", mem_wdata, e_wword);
            end else check("bus_quiet", {mem_addr, mem_wdata}, 0);
            if (rsp_valid) begin
                got = 1;
                check("latency", c, e_lat);
                check("rsp_rdata", rsp_rdata, e_rd);
                check("rsp_err", rsp_err, e_err);
            end else check("rsp_quiet", {rsp_rdata, rsp_err}, 0);
            req_valid = got ? 1'b0 : 1'($urandom);
            req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end
        if (!got) check("rsp_timeout", 0, 1);
        check("n_reads", nrd, e_nrd);
        check("n_writes", nwr, e_nwr);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < MEM_BYTES / 4; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
        end
        #12;
        check("rst_ready", req_ready, 1);
        check("rst_outs", {rsp_valid, rsp_err, mem_read, mem_write}, 0);
        check("rst_data", {rsp_rdata, mem_addr, mem_wdata}, 0);
        @(negedge clk); rst_n = 1;
        do_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF);
        do_req(0, 2'd2, 0, 32'h100, 0);
        check("deadbeef", {ref_mem[16'h103], ref_mem[16'h102], ref_mem[16'h101], ref_mem[16'h100]}, 32'hDEADBEEF);
        do_req(1, 2'd2, 0, 32'h100, 32'h11223344);
        do_req(1, 2'd0, 0, 32'h101, 32'h000000AA);
        check("rmw_model", ref_word(32'h100), 32'h1122AA44);
        do_req(1, 2'd2, 0, 32'h100, 32'h80FF0000);
        do_req(0, 2'd0, 0, 32'h103, 0);
        do_req(0, 2'd0, 1, 32'h103, 0);
        do_req(0, 2'd1, 0, 32'h102, 0);
        do_req(0, 2'd2, 0, 32'h102, 0);
        do_req(0, 2'd1, 1, 32'h101, 0);
        do_req(0, 2'd2, 0, 32'hFFFC, 0);
        do_req(0, 2'd2, 0, 32'hFFF8, 0);
        do_req(0, 2'd0, 0, 32'hFFFB, 0);
        do_req(0, 2'd3, 0, 32'h100, 0);
        do_req(1, 2'd3, 0, 32'h104, 32'h55);
        do_req(1, 2'd1, 0, 32'hFFFFFFF0, 32'h1234);
        // Reset during the write cycle of a word store must suppress the write and the response.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check("pre_rst_write", mem_write, 1);
        rst_n = 0;
        #1;
        check("rst_write_drop", mem_write, 0);
        check("rst_no_rsp", rsp_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_rsp", rsp_valid, 0);
        end
        rst_n = 1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_rsp", rsp_valid, 0);
        do_req(0, 2'd2, 0, 32'h100, 0);
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'(MEM_BYTES - 8 + $urandom_range(0, 7));
                default: a = 32'h100 + $urandom_range(0, 31);
            endcase
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory load/store interface, placed between the CPU execute stage and the byte-addressed little-endian data memory. Accepts one byte/half/word load or store request at a time and drives word-wide memory accesses.
- The memory reads combinationally and writes a full word at a clock edge, so sub-word stores use a read-modify-write sequence.
- Lane extraction and sign/zero extension for loads are done here.

Parameters:
MEM_BYTES, 65536, size of the data memory in bytes; aligned word address must be < MEM_BYTES-4.
ADDR_W, 32, width of request and memory addresses.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (IDLE only)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data; 0 for stores/errors
rsp_err  output  1  qualified by rsp_valid: misaligned, reserved size or out of range
mem_read  output  1  memory read enable (MemRead)
mem_write  output  1  memory write enable (MemWrite)
mem_addr  output  ADDR_W  word-aligned memory address
mem_wdata  output  32  memory write word
mem_rdata  input  32  memory read word, valid same cycle as mem_read

Behaviour:
- States: IDLE, LOAD, RMW_RD, STORE, RESP. Reset (async) → IDLE. All outputs 0 in reset except req_ready=1.
- IDLE: req_ready=1. Handshake on req_valid&&req_ready at an edge: latch we/size/unsigned/addr/wdata.
  - Error → RESP with err=1.
  - Load → LOAD.
  - Word store → STORE.
  - Byte/half store → RMW_RD.
- Error conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0; (addr & ~3) >= MEM_BYTES-4. Errored requests never assert mem_read/mem_write.
- LOAD: mem_read=1, mem_addr=addr&~3. Capture mem_rdata at the edge, select the lane, extend, then go to RESP.
  - Byte lane: bits [8k+7:8k], k=addr[1:0].
  - Half lane: bits [16h+15:16h], h=addr[1].
- RMW_RD: mem_read=1, same aligned address. Capture the word, replace the target lane with req_wdata[7:0] or [15:0], then go to STORE.
- STORE: mem_write=1, mem_addr aligned, mem_wdata = merged word (sub-word) or latched req_wdata (word). Then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_err driven. Then go to IDLE.
- Outside RESP: rsp_valid=0, rsp_rdata=0, rsp_err=0.
- mem_addr and mem_wdata are 0 whenever mem_read and mem_write are both 0. mem_read and mem_write are never both 1.
- Latency, counting the accept edge as cycle 0, rsp_valid is high in:
  - load: cycle 2
  - word store: cycle 2
  - sub-word store: cycle 3
  - error: cycle 1
- Throughput: next accept no earlier than the RESP cycle's edge+1. req_ready=0 in all non-IDLE states; req_valid there is ignored, with no latching.
- Reset mid-operation: immediate return to IDLE. mem_write drops asynchronously, so no write edge occurs after rst_n falls. A pending response is discarded.
- All address arithmetic is modulo 2^ADDR_W; no wrap detection beyond the range check.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned half/word requests complete with rsp_err=1 and make no memory access, as above.
- Undefined: misalignment is not an error. Low address bits are masked (half: addr&~1, word: addr&~3) and the access proceeds normally. Reserved size and out-of-range remain errors.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 → STORE cycle shows mem_write=1, mem_addr=0x100; load rsp_rdata=0xDEADBEEF, rsp_valid in cycle 2 after accept.
- Byte store 0xAA @0x101 over word 0x11223344 → RMW_RD then STORE with mem_wdata=0x1122AA44; rsp_valid in cycle 3.
- Byte load @0x103 of 0x80FF0000, signed → 0xFFFFFF80; unsigned → 0x00000080. Half load @0x102 signed → 0xFFFF80FF.
- Word load @0x102 → with MISALIGN_TRAP_EN: rsp_err=1 in cycle 1, mem_read never 1. Without it: access at 0x100, err=0.
- Word load @0xFFFC (MEM_BYTES-4) and size=11 request → rsp_err=1, rsp_rdata=0, no memory enable.
- Assert rst_n=0 during the STORE cycle of a word store → mem_write=0 immediately, no rsp_valid; after release req_ready=1, and a load of that address returns the old data.
